// File: rtl/timer_counter_array.sv
// Multi-channel up/down timer/counter array: per-channel prescaler, one-shot/auto-reload, software load, cascade.
// Optional capture unit enabled by defining TIMER_CAPTURE_EN.
module timer_counter_array #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         i_en,
    input  logic [NUM_CH-1:0]         i_reload,
    input  logic [NUM_CH-1:0]         i_count_up,
    input  logic [NUM_CH-1:0]         i_cascade,
    input  logic [NUM_CH-1:0]         i_sw_load,
    input  logic [NUM_CH*CNT_W-1:0]   i_load_value,
    input  logic [NUM_CH*CNT_W-1:0]   i_compare_value,
    input  logic [NUM_CH*PRESC_W-1:0] i_prescale,
    output logic [NUM_CH*CNT_W-1:0]   o_value,
    output logic [NUM_CH-1:0]         o_done,
`ifdef TIMER_CAPTURE_EN
    output logic [NUM_CH-1:0]         o_running,
    input  logic [NUM_CH-1:0]         i_capture,
    output logic [NUM_CH*CNT_W-1:0]   o_capture_value,
    output logic [NUM_CH-1:0]         o_capture_valid
`else
    output logic [NUM_CH-1:0]         o_running
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e             state_q [NUM_CH];
    state_e             state_d [NUM_CH];
    logic [CNT_W-1:0]   value_q [NUM_CH];
    logic [CNT_W-1:0]   value_d [NUM_CH];
    logic [PRESC_W-1:0] presc_q [NUM_CH];
    logic [PRESC_W-1:0] presc_d [NUM_CH];
    logic [NUM_CH-1:0]  done_q;
    logic [NUM_CH-1:0]  done_d;
    logic [NUM_CH-1:0]  tick;
    logic [NUM_CH:0]    done_chain;

    // Modulo-2^CNT_W step; wrap in both directions falls out of the fixed width.
    function automatic logic [CNT_W-1:0] count_step(input logic [CNT_W-1:0] v, input logic up);
        return up ? (v + CNT_W'(1)) : (v - CNT_W'(1));
    endfunction

    function automatic logic is_cascaded(input int k, input logic casc_bit);
        return (k != 0) && casc_bit;
    endfunction

    // done_chain[k] is the done pulse of channel k-1; channel 0 sees a constant 0.
    assign done_chain = {done_q, 1'b0};

    always_comb begin
        tick   = '0;
        done_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            state_d[k] = state_q[k];
            value_d[k] = value_q[k];
            presc_d[k] = presc_q[k];

            if (is_cascaded(k, i_cascade[k])) begin
                tick[k] = done_chain[k];
            end else begin
                tick[k] = (presc_q[k] == i_prescale[k*PRESC_W +: PRESC_W]);
            end

            if (!i_en[k]) begin
                state_d[k] = ST_IDLE;
                value_d[k] = i_load_value[k*CNT_W +: CNT_W];
                presc_d[k] = '0;
            end else begin
                case (state_q[k])
                    ST_IDLE: begin
                        state_d[k] = ST_RUN;
                        value_d[k] = i_load_value[k*CNT_W +: CNT_W];
                        presc_d[k] = '0;
                    end
                    ST_RUN: begin
                        if (i_sw_load[k]) begin
                            value_d[k] = i_load_value[k*CNT_W +: CNT_W];
                            presc_d[k] = '0;
                        end else begin
                            // Prescaler is bypassed and parked at 0 while cascaded.
                            if (is_cascaded(k, i_cascade[k]) || tick[k]) begin
                                presc_d[k] = '0;
                            end else begin
                                presc_d[k] = presc_q[k] + PRESC_W'(1);
                            end
                            if (tick[k]) begin
                                if (value_q[k] == i_compare_value[k*CNT_W +: CNT_W]) begin
                                    done_d[k] = 1'b1;
                                    if (i_reload[k]) begin
                                        value_d[k] = i_load_value[k*CNT_W +: CNT_W];
                                    end else begin
                                        state_d[k] = ST_HALT;
                                    end
                                end else begin
                                    value_d[k] = count_step(value_q[k], i_count_up[k]);
                                end
                            end
                        end
                    end
                    ST_HALT: begin
                        presc_d[k] = '0;
                        if (i_sw_load[k]) begin
                            state_d[k] = ST_RUN;
                            value_d[k] = i_load_value[k*CNT_W +: CNT_W];
                        end
                    end
                    default: begin
                        state_d[k] = ST_IDLE;
                        value_d[k] = i_load_value[k*CNT_W +: CNT_W];
                        presc_d[k] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= ST_IDLE;
                value_q[k] <= '0;
                presc_q[k] <= '0;
            end
            done_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= state_d[k];
                value_q[k] <= value_d[k];
                presc_q[k] <= presc_d[k];
            end
            done_q <= done_d;
        end
    end

    always_comb begin
        o_value   = '0;
        o_running = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            o_value[k*CNT_W +: CNT_W] = value_q[k];
            o_running[k]              = (state_q[k] == ST_RUN);
        end
    end

    assign o_done = done_q;

`ifdef TIMER_CAPTURE_EN
    logic [NUM_CH-1:0] cap_prev_q;
    logic [NUM_CH-1:0] cap_valid_q;
    logic [NUM_CH-1:0] cap_valid_d;
    logic [CNT_W-1:0]  cap_val_q [NUM_CH];
    logic [CNT_W-1:0]  cap_val_d [NUM_CH];

    always_comb begin
        cap_valid_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cap_val_d[k] = cap_val_q[k];
            if (i_capture[k] && !cap_prev_q[k] && (state_q[k] != ST_IDLE)) begin
                cap_val_d[k]   = value_q[k];
                cap_valid_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_prev_q  <= '0;
            cap_valid_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cap_val_q[k] <= '0;
            end
        end else begin
            cap_prev_q  <= i_capture;
            cap_valid_q <= cap_valid_d;
            for (int k = 0; k < NUM_CH; k++) begin
                cap_val_q[k] <= cap_val_d[k];
            end
        end
    end

    always_comb begin
        o_capture_value = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            o_capture_value[k*CNT_W +: CNT_W] = cap_val_q[k];
        end
    end

    assign o_capture_valid = cap_valid_q;
`endif

endmodule
